code_entry_checker: RTL and testbench

- Sequential consumer of the 4-bit equality comparator.
- Accepts a serial stream of 4-bit digits and checks each digit against a stored code using one `comparator_4bit` instance.
- Reports unlock or fail once a full code has been entered, counts consecutive failures, and enforces a timed lockout.
- Sits between the keypad/digit-entry front end and the unlock actuator logic.

---
 rtl/comparator_4bit.sv | 13 +
 rtl/code_entry_checker.sv | 139 +++++++++++++
 tb/tb_code_entry_checker.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/comparator_4bit.sv
// 4-bit equality comparator: eq is high when a and b are identical.
module comparator_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       eq
);

  // Pure combinational equality.
  always_comb begin
    eq = (a == b);
  end

endmodule

// File: rtl/code_entry_checker.sv
// Serial code-entry checker: compares a digit stream against a stored code,
// pulses unlock/fail per attempt, counts consecutive failures and enforces a
// timed lockout once too many wrong attempts have been made.
module code_entry_checker #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 16,
  parameter logic [31:0] RESET_CODE     = 32'h0000_1234
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            digit_in,
  input  logic                  digit_valid,
  input  logic                  cancel,
  input  logic [4*DIGITS-1:0]   code_in,
  input  logic                  code_we,
  output logic                  unlock,
  output logic                  fail,
  output logic                  locked_out,
  output logic                  busy,
  output logic [3:0]            digit_count
);

  localparam int unsigned CW = 4 * DIGITS;
  localparam int unsigned FW = $clog2(MAX_FAILS + 1);
  localparam int unsigned TW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [CW-1:0] RstCode = RESET_CODE[CW-1:0];

  typedef enum logic [1:0] {StIdle, StEntry, StLockout} state_e;

  state_e          state_q;
  logic [CW-1:0]   code_q;
  logic [3:0]      idx_q;
  logic            mismatch_q;
  logic [FW-1:0]   fail_cnt_q;
  logic [TW-1:0]   timer_q;

  logic [CW-1:0]   code_shift;
  logic [3:0]      cur_digit;
  logic            equal;
  logic            final_mismatch;
  logic [FW-1:0]   fail_next;
  logic            last_digit;

  // Select the stored digit at the current index; digit 0 sits in the low nibble.
  always_comb begin
    code_shift     = code_q >> {idx_q, 2'b00};
    cur_digit      = code_shift[3:0];
    final_mismatch = mismatch_q | ~equal;
    fail_next      = fail_cnt_q + FW'(1);
    last_digit     = (idx_q == 4'(DIGITS - 1));
  end

  comparator_4bit u_cmp (
    .a  (digit_in),
    .b  (cur_digit),
    .eq (equal)
  );

  assign digit_count = idx_q;

  // Single FSM: state, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      code_q     <= RstCode;
      idx_q      <= 4'd0;
      mismatch_q <= 1'b0;
      fail_cnt_q <= '0;
      timer_q    <= '0;
      unlock     <= 1'b0;
      fail       <= 1'b0;
      locked_out <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unlock <= 1'b0;
      fail   <= 1'b0;
      unique case (state_q)
        StIdle, StEntry: begin
          // In IDLE idx is always 0, so the load condition reduces to the state.
          if (state_q == StIdle && code_we) begin
            code_q <= code_in;
          end
          if (cancel) begin
            state_q    <= StIdle;
            idx_q      <= 4'd0;
            mismatch_q <= 1'b0;
            busy       <= 1'b0;
          end else if (digit_valid) begin
            if (last_digit) begin
              idx_q      <= 4'd0;
              mismatch_q <= 1'b0;
              if (!final_mismatch) begin
                unlock     <= 1'b1;
                fail_cnt_q <= '0;
                state_q    <= StIdle;
                busy       <= 1'b0;
              end else begin
                fail <= 1'b1;
                if (fail_next == FW'(MAX_FAILS)) begin
                  state_q    <= StLockout;
                  timer_q    <= TW'(LOCKOUT_CYCLES);
                  fail_cnt_q <= '0;
                  locked_out <= 1'b1;
                  busy       <= 1'b1;
                end else begin
                  fail_cnt_q <= fail_next;
                  state_q    <= StIdle;
                  busy       <= 1'b0;
                end
              end
            end else begin
              idx_q      <= idx_q + 4'd1;
              mismatch_q <= final_mismatch;
              state_q    <= StEntry;
              busy       <= 1'b1;
            end
          end
        end
        StLockout: begin
          // Leaving on the edge where the timer would hit 0 keeps locked_out
          // high for exactly LOCKOUT_CYCLES cycles.
          if (timer_q <= TW'(1)) begin
            timer_q    <= '0;
            state_q    <= StIdle;
            locked_out <= 1'b0;
            busy       <= 1'b0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_entry_checker.sv
// Directed bench for code_entry_checker with default parameters (4 digits,
// code 1234, 3 fails to lock, 16-cycle lockout).
module tb_code_entry_checker;

  logic        clk;
  logic        rst_n;
  logic [3:0]  digit_in;
  logic        digit_valid;
  logic        cancel;
  logic [15:0] code_in;
  logic        code_we;
  logic        unlock;
  logic        fail;
  logic        locked_out;
  logic        busy;
  logic [3:0]  digit_count;

  int total;
  int bad;

  code_entry_checker dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .cancel      (cancel),
    .code_in     (code_in),
    .code_we     (code_we),
    .unlock      (unlock),
    .fail        (fail),
    .locked_out  (locked_out),
    .busy        (busy),
    .digit_count (digit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; return 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present four digits on consecutive cycles (first argument is digit 0).
  task automatic enter4(input logic [3:0] d0, input logic [3:0] d1,
                        input logic [3:0] d2, input logic [3:0] d3);
    logic [3:0] ds [4];
    ds = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) begin
      digit_valid = 1'b1;
      digit_in    = ds[i];
      tick();
    end
    digit_valid = 1'b0;
    digit_in    = 4'h0;
  endtask

  // Wait out an active lockout; returns the number of sampled high cycles
  // after the current one.
  task automatic wait_lockout(output int cycles);
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!locked_out) break;
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; digit_in = 4'h0; digit_valid = 1'b0; cancel = 1'b0;
    code_in = 16'h0; code_we = 1'b0;
    #12;
    total++; if (unlock !== 1'b0) begin bad++; $display("FAIL reset_unlock got=%b want=0", unlock); end
    total++; if (fail !== 1'b0) begin bad++; $display("FAIL reset_fail got=%b want=0", fail); end
    total++; if (locked_out !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b want=0", locked_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (digit_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", digit_count); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_unlock();
    logic [3:0] ds [4];
    ds = '{4'h4, 4'h3, 4'h2, 4'h1};
    for (int i = 0; i < 3; i++) begin
      digit_valid = 1'b1; digit_in = ds[i];
      tick();
      total++;
      if (digit_count !== 4'(i + 1) || busy !== 1'b1) begin
        bad++; $display("FAIL unlock_progress got count=%0d busy=%b want count=%0d busy=1",
                        digit_count, busy, i + 1);
      end
    end
    digit_in = ds[3];
    tick();
    digit_valid = 1'b0;
    total++; if (unlock !== 1'b1 || fail !== 1'b0) begin bad++; $display("FAIL unlock_pulse got unlock=%b fail=%b want 1/0", unlock, fail); end
    total++; if (digit_count !== 4'd0 || busy !== 1'b0) begin bad++; $display("FAIL unlock_idle got count=%0d busy=%b want 0/0", digit_count, busy); end
    tick();
    total++; if (unlock !== 1'b0) begin bad++; $display("FAIL unlock_width got=%b want=0", unlock); end
  endtask

  task automatic test_fail_then_unlock();
    enter4(4'h4, 4'h3, 4'h2, 4'h0);
    total++; if (fail !== 1'b1 || unlock !== 1'b0 || locked_out !== 1'b0) begin bad++; $display("FAIL wrong_pulse got fail=%b unlock=%b lock=%b want 1/0/0", fail, unlock, locked_out); end
    tick();
    total++; if (fail !== 1'b0) begin bad++; $display("FAIL wrong_width got=%b want=0", fail); end
    enter4(4'h4, 4'h3, 4'h2, 4'h1);
    total++; if (unlock !== 1'b1) begin bad++; $display("FAIL unlock_after_fail got=%b want=1", unlock); end
    tick();
  endtask

  task automatic test_lockout();
    int cycles;
    for (int a = 0; a < 2; a++) begin
      enter4(4'h0, 4'h0, 4'h0, 4'h0);
      total++; if (fail !== 1'b1 || locked_out !== 1'b0) begin bad++; $display("FAIL lock_early attempt=%0d got fail=%b lock=%b want 1/0", a, fail, locked_out); end
    end
    enter4(4'h0, 4'h0, 4'h0, 4'h0);
    total++; if (fail !== 1'b1 || locked_out !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL lock_enter got fail=%b lock=%b busy=%b want 1/1/1", fail, locked_out, busy); end
    // Keep presenting the correct first digit; it must be ignored.
    digit_valid = 1'b1; digit_in = 4'h4; cancel = 1'b0;
    cycles = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!locked_out) break;
      cycles++;
      total++; if (digit_count !== 4'd0 || unlock !== 1'b0 || fail !== 1'b0) begin bad++; $display("FAIL lock_ignore got count=%0d unlock=%b fail=%b want 0/0/0", digit_count, unlock, fail); end
    end
    digit_valid = 1'b0;
    total++; if (cycles !== 16) begin bad++; $display("FAIL lock_length got=%0d want=16", cycles); end
    total++; if (busy !== 1'b0 || digit_count !== 4'd0) begin bad++; $display("FAIL lock_exit got busy=%b count=%0d want 0/0", busy, digit_count); end
    // Correct code starting on the first cycle after lockout.
    enter4(4'h4, 4'h3, 4'h2, 4'h1);
    total++; if (unlock !== 1'b1) begin bad++; $display("FAIL unlock_after_lock got=%b want=1", unlock); end
    tick();
  endtask

  task automatic test_cancel();
    int cycles;
    enter4(4'h1, 4'h1, 4'h1, 4'h1);
    enter4(4'h1, 4'h1, 4'h1, 4'h1);
    digit_valid = 1'b1; digit_in = 4'h4; tick();
    digit_in = 4'h3; tick();
    cancel = 1'b1; digit_in = 4'h2; tick();
    cancel = 1'b0; digit_valid = 1'b0;
    total++; if (digit_count !== 4'd0 || busy !== 1'b0 || unlock !== 1'b0 || fail !== 1'b0) begin bad++; $display("FAIL cancel got count=%0d busy=%b unlock=%b fail=%b want 0/0/0/0", digit_count, busy, unlock, fail); end
    tick();
    total++; if (unlock !== 1'b0 || fail !== 1'b0) begin bad++; $display("FAIL cancel_nopulse got unlock=%b fail=%b want 0/0", unlock, fail); end
    // Two fails were counted before the cancel; one more must lock out.
    enter4(4'h9, 4'h9, 4'h9, 4'h9);
    total++; if (locked_out !== 1'b1) begin bad++; $display("FAIL cancel_keeps_count got lock=%b want=1", locked_out); end
    wait_lockout(cycles);
    enter4(4'h4, 4'h3, 4'h2, 4'h1);
    total++; if (unlock !== 1'b1) begin bad++; $display("FAIL cancel_then_unlock got=%b want=1", unlock); end
    tick();
  endtask

  task automatic test_code_we();
    code_we = 1'b1; code_in = 16'hA5C3; tick();
    code_we = 1'b0;
    enter4(4'h3, 4'hC, 4'h5, 4'hA);
    total++; if (unlock !== 1'b1) begin bad++; $display("FAIL new_code_unlock got=%b want=1", unlock); end
    tick();
    enter4(4'h4, 4'h3, 4'h2, 4'h1);
    total++; if (fail !== 1'b1 || unlock !== 1'b0) begin bad++; $display("FAIL old_code_fails got fail=%b unlock=%b want 1/0", fail, unlock); end
    tick();
    // Load attempt while in ENTRY is ignored.
    digit_valid = 1'b1; digit_in = 4'h3; tick();
    code_we = 1'b1; code_in = 16'h1234; digit_in = 4'hC; tick();
    code_we = 1'b0; digit_in = 4'h5; tick();
    digit_in = 4'hA; tick();
    digit_valid = 1'b0;
    total++; if (unlock !== 1'b1) begin bad++; $display("FAIL we_in_entry got unlock=%b want=1", unlock); end
    tick();
    // Load together with the first digit: digit 0 checked against the old code.
    code_we = 1'b1; code_in = 16'h1234; digit_valid = 1'b1; digit_in = 4'h3; tick();
    code_we = 1'b0; digit_in = 4'h3; tick();
    digit_in = 4'h2; tick();
    digit_in = 4'h1; tick();
    digit_valid = 1'b0;
    total++; if (unlock !== 1'b1) begin bad++; $display("FAIL we_with_digit got unlock=%b want=1", unlock); end
    tick();
  endtask

  task automatic test_back_to_back();
    enter4(4'h4, 4'h3, 4'h2, 4'h1);
    total++; if (unlock !== 1'b1) begin bad++; $display("FAIL b2b_first got=%b want=1", unlock); end
    digit_valid = 1'b1; digit_in = 4'h4; tick();
    total++; if (digit_count !== 4'd1 || unlock !== 1'b0) begin bad++; $display("FAIL b2b_start got count=%0d unlock=%b want 1/0", digit_count, unlock); end
    digit_in = 4'h3; tick();
    digit_in = 4'h2; tick();
    digit_in = 4'h1; tick();
    digit_valid = 1'b0;
    total++; if (unlock !== 1'b1) begin bad++; $display("FAIL b2b_second got=%b want=1", unlock); end
    tick();
  endtask

  task automatic test_async_reset();
    code_we = 1'b1; code_in = 16'hA5C3; tick();
    code_we = 1'b0;
    digit_valid = 1'b1; digit_in = 4'h3; tick();
    digit_in = 4'hC; tick();
    digit_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (digit_count !== 4'd0 || busy !== 1'b0 || unlock !== 1'b0 || fail !== 1'b0) begin bad++; $display("FAIL rst_mid_entry got count=%0d busy=%b unlock=%b fail=%b want 0", digit_count, busy, unlock, fail); end
    #3 rst_n = 1'b1;
    tick();
    enter4(4'h4, 4'h3, 4'h2, 4'h1);
    total++; if (unlock !== 1'b1) begin bad++; $display("FAIL rst_code_restored got=%b want=1", unlock); end
    tick();
    for (int a = 0; a < 3; a++) enter4(4'h0, 4'h0, 4'h0, 4'h0);
    tick(); tick();
    total++; if (locked_out !== 1'b1) begin bad++; $display("FAIL rst_pre_lock got=%b want=1", locked_out); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (locked_out !== 1'b0 || busy !== 1'b0 || fail !== 1'b0) begin bad++; $display("FAIL rst_mid_lock got lock=%b busy=%b fail=%b want 0/0/0", locked_out, busy, fail); end
    #3 rst_n = 1'b1;
    tick();
    enter4(4'h4, 4'h3, 4'h2, 4'h1);
    total++; if (unlock !== 1'b1) begin bad++; $display("FAIL rst_after_lock got=%b want=1", unlock); end
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_unlock();
    test_fail_then_unlock();
    test_lockout();
    test_cancel();
    test_code_we();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
